// File: rtl/fetch_buffer_pkg.sv
// Shared fetch/decode types and constants: entry layout, widths, PC step
// and the ripple-carry adder used for PC+4.
package fetch_buffer_pkg;

    localparam int unsigned INS_W   = 32;
    localparam int unsigned PC_W    = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [PC_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] ripple_add(
        input logic [PC_W-1:0] a,
        input logic [PC_W-1:0] b,
        input logic            cin
    );
        logic [PC_W-1:0] sum;
        logic            carry;
        sum   = '0;
        carry = cin;
        for (int unsigned i = 0; i < PC_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        return sum;
    endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// DEPTH x fetch_entry_t register array: one synchronous write port,
// one combinational read port. Contents are intentionally not reset.
module fetch_buffer_ram
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  fetch_entry_t  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output fetch_entry_t  o_rdata
);

    fetch_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_buffer.sv
// First-word-fall-through instruction buffer between fetch and decode,
// with PC+4 sideband, misalignment flag and synchronous flush.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INS_W-1:0] in_ins,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INS_W-1:0] out_ins,
    output logic [PC_W-1:0]  out_pc,
    output logic [PC_W-1:0]  out_pcp4,
    output logic             out_misaligned,
    input  logic             flush,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_clear;
    fetch_entry_t  w_wdata;
    fetch_entry_t  w_head;

    // Ready depends only on registered occupancy, so a pop cannot free a slot
    // for a push in the same cycle.
    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign w_clear   = rst | flush;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_wdata.ins = in_ins;
    assign w_wdata.pc  = in_pc;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fetch_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push & ~w_clear),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_head)
    );

    assign out_ins        = w_head.ins;
    assign out_pc         = w_head.pc;
    assign out_pcp4       = ripple_add(w_head.pc, PC_STEP, 1'b0);
    assign out_misaligned = (w_head.pc[1:0] != 2'b00);
    assign count          = r_count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed + randomized bench for fetch_buffer against a queue-based model.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [INS_W-1:0] in_ins;
    logic [PC_W-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [INS_W-1:0] out_ins;
    logic [PC_W-1:0]  out_pc;
    logic [PC_W-1:0]  out_pcp4;
    logic             out_misaligned;
    logic             flush;
    logic [AW:0]      count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    fetch_entry_t model_q[$];

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_ins         (in_ins),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc),
        .out_pcp4       (out_pcp4),
        .out_misaligned (out_misaligned),
        .flush          (flush),
        .count          (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model's view of the queue.
    task automatic check_model();
        int unsigned sz;
        sz = model_q.size();
        check("count", 32'(count), sz);
        check("out_valid", 32'(out_valid), 32'(sz != 0));
        check("in_ready", 32'(in_ready), 32'(sz != DEPTH));
        if (sz != 0) begin
            check("out_ins", out_ins, model_q[0].ins);
            check("out_pc", out_pc, model_q[0].pc);
            check("out_pcp4", out_pcp4, model_q[0].pc + 32'd4);
            check("out_misaligned", 32'(out_misaligned), 32'(model_q[0].pc[1:0] != 2'b00));
        end
    endtask

    // Check settled outputs, take one clock edge, advance the model.
    task automatic cycle();
        logic do_push, do_pop;
        fetch_entry_t e;
        #1;
        check_model();
        do_push = in_valid && (model_q.size() != DEPTH);
        do_pop  = out_ready && (model_q.size() != 0);
        e.ins = in_ins;
        e.pc  = in_pc;
        @(posedge clk);
        if (rst || flush) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_ins    = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        cycle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ins = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;

        // Reset held two cycles, then idle.
        @(posedge clk); #1;
        cycle();
        cycle();
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b0);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Fill to full with decode stalled; fifth push is refused.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0050_0093 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(count), 32'd4);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_pcp4", out_pcp4, 32'(4 * (i + 1)));
            check("drain_ins", out_ins, 32'h0050_0093 + 32'(i));
            drive(1'b0, '0, '0, 1'b1, 1'b0);
        end
        check("drained_out_valid", 32'(out_valid), 32'd0);

        // Streaming: one push and one pop per cycle.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 32'h0000_1000 + 32'(4 * i), 1'b1, 1'b0);
            check("stream_count", 32'(count), 32'd1);
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush wins over a same-cycle push and pop.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hB0 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
        check("preflush_count", 32'(count), 32'd3);
        drive(1'b1, 32'hDEAD_BEEF, 32'h300, 1'b1, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);

        // Full with simultaneous pop: pop happens, push refused.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'hC0 + 32'(i), 32'h400 + 32'(4 * i), 1'b0, 1'b0);
        drive(1'b1, 32'hC4, 32'h410, 1'b1, 1'b0);
        check("fullpop_count", 32'(count), 32'd3);
        drive(1'b0, '0, '0, 1'b0, 1'b1);

        // Edge PCs: wrap-around PC+4 and a misaligned PC.
        drive(1'b1, 32'h1111_1111, 32'hFFFF_FFFC, 1'b0, 1'b0);
        drive(1'b1, 32'h2222_2222, 32'h0000_0102, 1'b0, 1'b0);
        #1;
        check("wrap_pcp4", out_pcp4, 32'h0000_0000);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        #1;
        check("misaligned", 32'(out_misaligned), 32'd1);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Pointer wrap with more than 2*DEPTH pushes through a half-full buffer.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(1'b1, 32'hE000 + 32'(i), 32'h800 + 32'(4 * i), i[0], 1'b0);
        end

        // Randomized traffic including occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = $urandom();
            if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
            rst = ($urandom_range(0, 96) == 0);
            drive($urandom_range(0, 3) != 0, $urandom(), pc,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        check_model();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch buffer between the fetch stage and the decode stage. Captures fetched instruction/PC pairs from fetch, holds up to DEPTH of them in a first-word-fall-through queue, and presents them to decode with a valid/ready handshake. Provides PC+4 alongside each instruction and a synchronous flush for taken branches and jumps. Decouples decode stalls from instruction-memory timing.

## Interface
- DEPTH, 4, number of entries; power of two, 2..16
- AW, $clog2(DEPTH), pointer width (derived, not overridden)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction this cycle
- in_ready  out  1  buffer accepts this cycle; equals !full
- in_ins  in  32  fetched instruction word
- in_pc  in  32  PC of in_ins
- out_valid  out  1  head entry valid; equals count != 0
- out_ready  in  1  decode consumes head this cycle
- out_ins  out  32  head instruction
- out_pc  out  32  head PC
- out_pcp4  out  32  out_pc + 4, modulo 2^32
- out_misaligned  out  1  out_pc[1:0] != 2'b00
- flush  in  1  discard all entries (taken branch/jump)
- count  out  AW+1  current occupancy, 0..DEPTH

## Operation
- Push: in_valid && in_ready stores {in_ins, in_pc} at write pointer; wptr increments, wraps DEPTH-1 -> 0.
- Pop: out_valid && out_ready retires head; rptr increments with same wrap.
- in_ready = (count != DEPTH). No pass-through when full: push when full is refused even if pop occurs same cycle.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Push while empty: entry is not visible until next cycle (no combinational in->out bypass).
- Pop while empty: ignored (out_valid=0); pointers and count unchanged.
- flush: wptr, rptr, count cleared to 0 next cycle; any push or pop in the same cycle is discarded. flush has priority over everything except rst.
- out_ins/out_pc are the storage contents at rptr; when out_valid=0 their values are don't-care, but out_valid, in_ready, count are always defined.
- out_pcp4 derived combinationally from out_pc; carry out of bit 31 discarded.
- out_misaligned is informational; entries flow normally.
- Storage array is not reset; only pointers and count are.

## Timing
- Reset (rst=1 at a rising edge): count=0, out_valid=0, in_ready=1, pointers 0. rst mid-operation drops all entries identically to flush.
- Latency: word pushed at edge N appears at out (out_valid=1) after edge N, i.e. usable in cycle N+1 if buffer was empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full: count=DEPTH -> in_ready=0 in the same cycle; deasserts combinationally from registered count only (no dependency on out_ready).
- Empty after last pop: out_valid=0 in the cycle following the pop edge.
- After flush at edge N: out_valid=0, in_ready=1, count=0 in cycle N+1.
- Handshakes: producer holds in_ins/in_pc stable while in_valid && !in_ready; buffer holds out_* stable while out_valid && !out_ready.

## Structure
- Shared package: INS_W=32, PC_W=32, PC_STEP=32'd4, and a packed fetch-entry typedef {ins, pc} reused by fetch and decode stages.
- One sub-module: fetch_buffer_ram, a DEPTH x 64 register array with one synchronous write port and one combinational read port; control (pointers, count, flags) stays in fetch_buffer.
- PC+4 uses the existing 32-bit ripple adder with cin=0.

## Test plan
- Reset: assert rst 2 cycles -> count=0, out_valid=0, in_ready=1; release, no traffic -> unchanged.
- Fill/drain: out_ready=0, push pc 0x0,0x4,0x8,0xC with ins 0x00500093.. -> in_ready=0 after 4th, 5th push refused; then out_ready=1 -> pops in order, out_pcp4 = 0x4,0x8,0xC,0x10, out_valid=0 after 4th.
- Streaming: in_valid=out_ready=1 for 20 cycles, pc incrementing by 4 -> one retire per cycle, count stays 1, order preserved.
- Flush priority: count=3, flush=1 with in_valid=out_ready=1 same cycle -> next cycle count=0, out_valid=0, pushed word absent.
- Full + pop same cycle: count=4, in_valid=1, out_ready=1 -> pop occurs, push refused, count=3.
- Wrap and edge values: in_pc=0xFFFFFFFC -> out_pcp4=0x00000000; in_pc=0x00000102 -> out_misaligned=1; run >2*DEPTH pushes to exercise pointer wrap.
